// File: rtl/tex_texel_fetch.sv
// Texel fetch: turns resolved texel coordinates into texel values, issuing memory
// reads for in-bounds texels and answering border texels locally, in request order.
module tex_texel_fetch #(
  parameter int W       = 12,
  parameter int ADDR_W  = 32,
  parameter int TEXEL_W = 32,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_x,
  input  logic [W-1:0]       in_y,
  input  logic               in_border,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [W-1:0]       pitch,
  input  logic [TEXEL_W-1:0] border_color,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [ADDR_W-1:0]  mem_req_addr,
  input  logic               mem_rsp_valid,
  input  logic [TEXEL_W-1:0] mem_rsp_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TEXEL_W-1:0] out_data,
  output logic               err
);
  localparam int SH = $clog2(TEXEL_W / 8);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic               border;
    logic [TEXEL_W-1:0] color;
  } ord_t;

  ord_t               ord_mem [DEPTH];
  logic [TEXEL_W-1:0] rsp_mem [DEPTH];
  logic [PW-1:0]      ord_wp, ord_rp, rsp_wp, rsp_rp;
  logic [CW-1:0]      occ, rcnt, pend;
  logic               req_valid;
  logic [ADDR_W-1:0]  req_addr;

  logic [2*W-1:0]     lin;
  logic [2*W+2:0]     lin_b;
  logic [ADDR_W-1:0]  addr;
  logic               accept, mem_hs, rsp_wr, pop, rsp_pop;
  ord_t               head;

  assign lin   = (2*W)'(in_y) * (2*W)'(pitch) + (2*W)'(in_x);
  assign lin_b = {3'b000, lin} << SH;
  assign addr  = base_addr + ADDR_W'(lin_b);

  // Slot check uses current occupancy only; a same-cycle pop does not free a slot.
  assign in_ready = !rst && (occ < CW'(DEPTH)) && (!req_valid || mem_req_ready);
  assign accept   = in_valid && in_ready;
  assign mem_hs   = req_valid && mem_req_ready;
  assign rsp_wr   = mem_rsp_valid && (pend != '0);

  assign head      = ord_mem[ord_rp];
  assign out_valid = (occ != '0) && (head.border || rcnt != '0);
  assign out_data  = !out_valid ? '0 : (head.border ? head.color : rsp_mem[rsp_rp]);
  assign pop       = out_valid && out_ready;
  assign rsp_pop   = pop && !head.border;

  assign mem_req_valid = req_valid;
  assign mem_req_addr  = req_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ord_wp    <= '0;
      ord_rp    <= '0;
      rsp_wp    <= '0;
      rsp_rp    <= '0;
      occ       <= '0;
      rcnt      <= '0;
      pend      <= '0;
      req_valid <= 1'b0;
      req_addr  <= '0;
      err       <= 1'b0;
    end else begin
      if (accept)  ord_wp <= ord_wp + PW'(1);
      if (pop)     ord_rp <= ord_rp + PW'(1);
      if (rsp_wr)  rsp_wp <= rsp_wp + PW'(1);
      if (rsp_pop) rsp_rp <= rsp_rp + PW'(1);
      occ  <= occ  + CW'(accept) - CW'(pop);
      rcnt <= rcnt + CW'(rsp_wr) - CW'(rsp_pop);
      pend <= pend + CW'(mem_hs) - CW'(rsp_wr);
      // A reload in the handshake cycle wins over the clear.
      if (accept && !in_border) begin
        req_valid <= 1'b1;
        req_addr  <= addr;
      end else if (mem_hs) begin
        req_valid <= 1'b0;
      end
      if (mem_rsp_valid && pend == '0) err <= 1'b1;
    end
  end

  // Payload storage needs no reset: occupancy counts gate every read.
  always_ff @(posedge clk) begin
    if (accept) ord_mem[ord_wp] <= '{border: in_border, color: border_color};
    if (rsp_wr) rsp_mem[rsp_wp] <= mem_rsp_data;
  end
endmodule

// File: tb/tb_tex_texel_fetch.sv
// Bench for tex_texel_fetch: directed scenarios plus a randomized run checked
// against an in-order reference queue and a latency-modelled memory.
module tb_tex_texel_fetch;
  localparam int W = 12, ADDR_W = 32, TEXEL_W = 32, DEPTH = 4, BPT = TEXEL_W / 8;

  logic clk, rst;
  logic in_valid, in_ready, in_border;
  logic [W-1:0] in_x, in_y, pitch;
  logic [ADDR_W-1:0] base_addr, mem_req_addr;
  logic [TEXEL_W-1:0] border_color, mem_rsp_data, out_data;
  logic mem_req_valid, mem_req_ready, mem_rsp_valid, out_valid, out_ready, err;

  int passed = 0, total = 0, cyc = 0, n_acc = 0, lat = 1;
  bit auto_mem = 0;
  logic [31:0] exp_q[$], got_q[$], exp_addr_q[$], got_addr_q[$], memq_addr[$];
  int memq_due[$];

  tex_texel_fetch #(.W(W), .ADDR_W(ADDR_W), .TEXEL_W(TEXEL_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .in_border(in_border), .base_addr(base_addr), .pitch(pitch), .border_color(border_color),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .err(err));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] model_addr(input logic [W-1:0] x, input logic [W-1:0] y);
    longint unsigned lin, b;
    lin = longint'(y) * longint'(pitch) + longint'(x);
    b   = longint'(base_addr);
    return 32'(b + lin * BPT);
  endfunction

  // One clock: observe the handshakes about to happen at the next edge, update the
  // reference model and the memory responder, then advance to the next falling edge.
  task automatic cycle();
    logic [31:0] ea;
    #1;
    if (in_valid && in_ready) begin
      n_acc++;
      if (in_border) exp_q.push_back(border_color);
      else begin
        ea = model_addr(in_x, in_y);
        exp_q.push_back(mem_fn(ea));
        exp_addr_q.push_back(ea);
      end
    end
    if (mem_req_valid && mem_req_ready) begin
      got_addr_q.push_back(mem_req_addr);
      if (auto_mem) begin
        memq_addr.push_back(mem_req_addr);
        memq_due.push_back(cyc + 1 + lat);
      end
    end
    if (out_valid && out_ready) got_q.push_back(out_data);
    if (auto_mem) begin
      if (memq_due.size() > 0 && memq_due[0] <= cyc + 1) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem_fn(memq_addr.pop_front());
        void'(memq_due.pop_front());
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit b,
                       input logic [31:0] c, output bit ok);
    int n0;
    ok = 0;
    in_x = x; in_y = y; in_border = b; border_color = c; in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      n0 = n_acc;
      cycle();
      ok = (n_acc != n0);
    end
    in_valid = 1'b0;
  endtask

  task automatic clear_model();
    exp_q.delete(); got_q.delete(); exp_addr_q.delete(); got_addr_q.delete();
    memq_addr.delete(); memq_due.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 0; mem_rsp_valid = 0; mem_rsp_data = '0; out_ready = 0; mem_req_ready = 0;
    auto_mem = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    @(negedge clk);
    total++; if ({in_ready, mem_req_valid, out_valid, err} !== 4'b0000)
      $display("FAIL reset_flags: got %b want 0000", {in_ready, mem_req_valid, out_valid, err});
    else passed++;
    total++; if ({mem_req_addr, out_data} !== 64'h0)
      $display("FAIL reset_data: got %h want 0", {mem_req_addr, out_data});
    else passed++;
    rst = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    bit ok;
    do_reset();
    base_addr = 32'h1000; pitch = 12'd256;
    issue(12'd3, 12'd2, 1'b0, 32'h0, ok);
    total++; if (!ok || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h180C)
      $display("FAIL fetch_addr: got v=%b addr=%h want v=1 addr=0000180c", mem_req_valid, mem_req_addr);
    else passed++;
    mem_req_ready = 1'b1; cycle(); mem_req_ready = 1'b0;
    total++; if (mem_req_valid !== 1'b0) $display("FAIL fetch_req_clear: got %b want 0", mem_req_valid);
    else passed++;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADBEEF;
    total++; if (out_valid !== 1'b0) $display("FAIL fetch_early_out: got %b want 0", out_valid);
    else passed++;
    cycle(); mem_rsp_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF)
      $display("FAIL fetch_data: got v=%b d=%h want v=1 d=deadbeef", out_valid, out_data);
    else passed++;
    out_ready = 1'b1; cycle(); out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL fetch_pop: got %b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_border();
    bit ok;
    do_reset();
    issue(12'd9, 12'd9, 1'b1, 32'h11223344, ok);
    border_color = 32'h99999999;
    total++; if (!ok || mem_req_valid !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h11223344)
      $display("FAIL border: got req=%b v=%b d=%h want req=0 v=1 d=11223344",
               mem_req_valid, out_valid, out_data);
    else passed++;
  endtask

  task automatic test_ordering();
    bit ok1, ok2, ok3;
    logic [31:0] ea, ec;
    do_reset();
    auto_mem = 1; lat = 5; mem_req_ready = 1; out_ready = 1;
    base_addr = 32'h4000; pitch = 12'd100;
    ea = mem_fn(model_addr(12'd1, 12'd1));
    ec = mem_fn(model_addr(12'd7, 12'd3));
    issue(12'd1, 12'd1, 1'b0, 32'h0, ok1);
    issue(12'd0, 12'd0, 1'b1, 32'hB0B0B0B0, ok2);
    issue(12'd7, 12'd3, 1'b0, 32'h0, ok3);
    for (int i = 0; i < 60 && got_q.size() < 3; i++) cycle();
    total++; if (!(ok1 && ok2 && ok3) || got_q.size() != 3)
      $display("FAIL order_count: got %0d want 3", got_q.size());
    else passed++;
    if (got_q.size() == 3) begin
      total++; if (got_q[0] !== ea || got_q[1] !== 32'hB0B0B0B0 || got_q[2] !== ec)
        $display("FAIL order_seq: got %h %h %h want %h b0b0b0b0 %h", got_q[0], got_q[1], got_q[2], ea, ec);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n0;
    logic [31:0] ea;
    do_reset();
    base_addr = 32'h2000; pitch = 12'd64;
    issue(12'd7, 12'd1, 1'b0, 32'h0, ok);
    ea = model_addr(12'd7, 12'd1);
    in_valid = 1'b1; in_border = 1'b0; in_x = 12'd8; in_y = 12'd1;
    n0 = n_acc;
    for (int i = 0; i < 10; i++) begin
      total++; if (in_ready !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== ea)
        $display("FAIL bp_hold: got rdy=%b v=%b a=%h want rdy=0 v=1 a=%h", in_ready, mem_req_valid, mem_req_addr, ea);
      else passed++;
      cycle();
    end
    in_valid = 1'b0;
    mem_req_ready = 1'b1; cycle(); mem_req_ready = 1'b0;
    in_valid = 1'b1; in_border = 1'b1; border_color = 32'h55;
    for (int i = 0; i < 8; i++) cycle();
    total++; if (n_acc - n0 != 3 || in_ready !== 1'b0)
      $display("FAIL bp_fill: got acc=%0d rdy=%b want acc=3 rdy=0", n_acc - n0, in_ready);
    else passed++;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE0001; cycle(); mem_rsp_valid = 1'b0;
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'hCAFE0001)
      $display("FAIL bp_head: got rdy=%b v=%b d=%h want rdy=0 v=1 d=cafe0001", in_ready, out_valid, out_data);
    else passed++;
    out_ready = 1'b1; cycle(); out_ready = 1'b0;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_release: got %b want 1", in_ready);
    else passed++;
    in_valid = 1'b0;
    got_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    total++; if (got_q.size() != 3 || got_q[0] !== 32'h55 || got_q[2] !== 32'h55)
      $display("FAIL bp_drain: got %0d entries want 3 of 00000055", got_q.size());
    else passed++;
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    base_addr = 32'hFFFFFFF0; pitch = 12'd100;
    issue(12'd5, 12'd0, 1'b0, 32'h0, ok);
    total++; if (!ok || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h4)
      $display("FAIL wrap_addr: got %h want 00000004", mem_req_addr);
    else passed++;
  endtask

  task automatic test_spurious_reset();
    bit ok;
    do_reset();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h77; cycle(); mem_rsp_valid = 1'b0;
    total++; if (err !== 1'b1) $display("FAIL spur_err: got %b want 1", err);
    else passed++;
    for (int i = 0; i < 3; i++) cycle();
    total++; if (err !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL spur_sticky: got err=%b v=%b want err=1 v=0", err, out_valid);
    else passed++;
    base_addr = 32'h1000; pitch = 12'd256;
    issue(12'd0, 12'd0, 1'b1, 32'hAA, ok);
    issue(12'd1, 12'd0, 1'b1, 32'hBB, ok);
    issue(12'd3, 12'd2, 1'b0, 32'h0, ok);
    total++; if (out_valid !== 1'b1 || mem_req_valid !== 1'b1)
      $display("FAIL inflight: got v=%b req=%b want 1 1", out_valid, mem_req_valid);
    else passed++;
    rst = 1'b1;
    #1;
    total++; if ({out_valid, mem_req_valid, err, in_ready} !== 4'b0000 || mem_req_addr !== 32'h0 || out_data !== 32'h0)
      $display("FAIL midreset: got flags=%b a=%h d=%h want 0000 0 0",
               {out_valid, mem_req_valid, err, in_ready}, mem_req_addr, out_data);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    auto_mem = 1; lat = 2; mem_req_ready = 1; out_ready = 1;
    issue(12'd3, 12'd2, 1'b0, 32'h0, ok);
    for (int i = 0; i < 30 && got_q.size() < 1; i++) cycle();
    total++; if (got_q.size() != 1 || got_q[0] !== mem_fn(32'h180C) || err !== 1'b0)
      $display("FAIL post_reset: got n=%0d err=%b want n=1 err=0 d=%h", got_q.size(), err, mem_fn(32'h180C));
    else passed++;
  endtask

  task automatic test_random();
    logic pv, pr;
    logic [31:0] pd;
    int bad;
    do_reset();
    auto_mem = 1;
    base_addr = $urandom; pitch = W'($urandom);
    for (int i = 0; i < 500; i++) begin
      in_valid = ($urandom % 3) != 0;
      in_border = ($urandom % 4) == 0;
      in_x = W'($urandom); in_y = W'($urandom); border_color = $urandom;
      mem_req_ready = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      lat = $urandom_range(1, 5);
      pv = out_valid; pr = out_ready; pd = out_data;
      cycle();
      if (pv && !pr) begin
        total++; if (out_valid !== 1'b1 || out_data !== pd)
          $display("FAIL rand_stall: got v=%b d=%h want v=1 d=%h", out_valid, out_data, pd);
        else passed++;
      end
    end
    in_valid = 1'b0; mem_req_ready = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 300 && (got_q.size() < exp_q.size() || memq_due.size() > 0); i++) cycle();
    total++; if (got_q.size() != exp_q.size() || got_addr_q.size() != exp_addr_q.size())
      $display("FAIL rand_count: got %0d/%0d want %0d/%0d", got_q.size(), got_addr_q.size(),
               exp_q.size(), exp_addr_q.size());
    else passed++;
    bad = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
    for (int i = 0; i < got_addr_q.size() && i < exp_addr_q.size(); i++)
      if (got_addr_q[i] !== exp_addr_q[i]) bad++;
    total++; if (bad != 0 || exp_q.size() == 0)
      $display("FAIL rand_stream: got %0d wrong of %0d want 0", bad, exp_q.size());
    else passed++;
    total++; if (err !== 1'b0) $display("FAIL rand_err: got %b want 0", err);
    else passed++;
  endtask

  initial begin
    clk = 0; rst = 1;
    in_valid = 0; in_x = '0; in_y = '0; in_border = 0; base_addr = '0; pitch = '0;
    border_color = '0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = '0; out_ready = 0;
    test_reset();
    test_fetch();
    test_border();
    test_ordering();
    test_backpressure();
    test_wrap();
    test_spurious_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
